// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction field encodings used by the core and
// the state type / constants of the data-port bus bridge.
package mips_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE  = 6'h00,
    OP_REGIMM = 6'h01,
    OP_J      = 6'h02,
    OP_JAL    = 6'h03,
    OP_BEQ    = 6'h04,
    OP_BNE    = 6'h05,
    OP_BLEZ   = 6'h06,
    OP_BGTZ   = 6'h07,
    OP_ADDIU  = 6'h09,
    OP_SLTI   = 6'h0A,
    OP_SLTIU  = 6'h0B,
    OP_ANDI   = 6'h0C,
    OP_ORI    = 6'h0D,
    OP_XORI   = 6'h0E,
    OP_LUI    = 6'h0F,
    OP_LB     = 6'h20,
    OP_LH     = 6'h21,
    OP_LWL    = 6'h22,
    OP_LW     = 6'h23,
    OP_LBU    = 6'h24,
    OP_LHU    = 6'h25,
    OP_LWR    = 6'h26,
    OP_SB     = 6'h28,
    OP_SH     = 6'h29,
    OP_SWL    = 6'h2A,
    OP_SW     = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL   = 6'h00,
    FN_SRL   = 6'h02,
    FN_SRA   = 6'h03,
    FN_SLLV  = 6'h04,
    FN_SRLV  = 6'h06,
    FN_SRAV  = 6'h07,
    FN_JR    = 6'h08,
    FN_JALR  = 6'h09,
    FN_MFHI  = 6'h10,
    FN_MTHI  = 6'h11,
    FN_MFLO  = 6'h12,
    FN_MTLO  = 6'h13,
    FN_MULT  = 6'h18,
    FN_MULTU = 6'h19,
    FN_DIV   = 6'h1A,
    FN_DIVU  = 6'h1B,
    FN_ADDU  = 6'h21,
    FN_SUBU  = 6'h23,
    FN_AND   = 6'h24,
    FN_OR    = 6'h25,
    FN_XOR   = 6'h26,
    FN_NOR   = 6'h27,
    FN_SLT   = 6'h2A,
    FN_SLTU  = 6'h2B
  } funct_t;

  typedef enum logic [2:0] {
    BR_IDLE   = 3'd0,
    BR_REQ    = 3'd1,
    BR_RDWAIT = 3'd2,
    BR_DONE   = 3'd3,
    BR_ERR    = 3'd4
  } bridge_state_t;

  localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

  function automatic logic is_load(input opcode_t op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LWL) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU) || (op == OP_LWR);
  endfunction

  function automatic logic is_store(input opcode_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SWL) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_data_bus_bridge.sv
// Bridges the CPU's single-cycle data port onto a wait-stated Avalon-MM bus,
// stalling the CPU via clk_enable and trapping protocol faults.
//
//   state  | meaning
//   IDLE   | sampling CPU inputs; non-memory instructions run at full rate
//   REQ    | strobe asserted from latched request, waiting for acceptance
//   RDWAIT | read accepted, capturing readdata this cycle
//   DONE   | transaction finished; one clk_enable pulse commits the instruction
//   ERR    | protocol fault, CPU frozen until reset
module mips_data_bus_bridge
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic        cpu_clk_enable,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        fault
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bridge_state_t    state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic             dir_write;
  logic             latch_en, capture;
  logic             req;

  assign req = cpu_data_read | cpu_data_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= BR_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      dir_write <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (latch_en) begin
        addr_q    <= cpu_data_address;
        wdata_q   <= cpu_data_writedata;
        dir_write <= cpu_data_write;
      end
      if (capture) begin
        rdata_q <= avm_readdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    latch_en   = 1'b0;
    capture    = 1'b0;
    unique case (state)
      BR_IDLE: begin
        if (cpu_data_read && cpu_data_write) begin
          state_next = BR_ERR;
        end else if (req && (cpu_data_address[1:0] != 2'b00)) begin
          state_next = BR_ERR;
        end else if (req) begin
          state_next = BR_REQ;
          latch_en   = 1'b1;
          cnt_next   = '0;
        end
      end
      BR_REQ: begin
        if (!avm_waitrequest) begin
          state_next = dir_write ? BR_DONE : BR_RDWAIT;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
          state_next = BR_ERR;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      BR_RDWAIT: begin
        capture    = 1'b1;
        state_next = BR_DONE;
      end
      // The old instruction's req is still high here; it must not be re-sampled.
      BR_DONE:  state_next = BR_IDLE;
      BR_ERR:   state_next = BR_ERR;
      default:  state_next = BR_IDLE;
    endcase
  end

  assign cpu_clk_enable    = !reset && (((state == BR_IDLE) && !req) || (state == BR_DONE));
  assign avm_read          = (state == BR_REQ) && !dir_write;
  assign avm_write         = (state == BR_REQ) && dir_write;
  assign avm_address       = addr_q;
  assign avm_writedata     = wdata_q;
  assign avm_byteenable    = BYTEENABLE_ALL;
  assign cpu_data_readdata = rdata_q;
  assign fault             = (state == BR_ERR);

endmodule

// File: tb/tb_mips_data_bus_bridge.sv
// Self-checking bench for mips_data_bus_bridge: directed table, hand-written
// corner sequences and a randomized instruction stream against a timing model.
module tb_mips_data_bus_bridge;
  import mips_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_data_address;
  logic        cpu_data_read;
  logic        cpu_data_write;
  logic [31:0] cpu_data_writedata;
  logic [31:0] cpu_data_readdata;
  logic        cpu_clk_enable;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_data_bus_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .cpu_data_address(cpu_data_address), .cpu_data_read(cpu_data_read),
    .cpu_data_write(cpu_data_write), .cpu_data_writedata(cpu_data_writedata),
    .cpu_data_readdata(cpu_data_readdata), .cpu_clk_enable(cpu_clk_enable),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest), .fault(fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    cpu_data_read      = 1'($urandom);
    cpu_data_write     = 1'($urandom);
    cpu_data_address   = $urandom;
    cpu_data_writedata = $urandom;
    avm_waitrequest    = 1'($urandom);
    avm_readdata       = $urandom;
    #1;
    chk("ce_during_reset", 32'(cpu_clk_enable), 32'd0);
    @(posedge clk); #1;
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_avm_read", 32'(avm_read), 32'd0);
    chk("rst_avm_write", 32'(avm_write), 32'd0);
    chk("rst_avm_address", avm_address, 32'd0);
    chk("rst_avm_writedata", avm_writedata, 32'd0);
    chk("rst_readdata", cpu_data_readdata, 32'd0);
    reset          = 1'b0;
    cpu_data_read  = 1'b0;
    cpu_data_write = 1'b0;
  endtask

  // Runs one CPU instruction. Expected per-cycle behaviour is derived from the
  // cycle-count rules: IDLE cycle, one bus cycle per wait plus acceptance,
  // an extra cycle for reads, then the commit cycle.
  task automatic do_instr(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int waits,
                          input logic [31:0] rdata, input bit scramble,
                          output int ce_at, output bit fault_seen);
    bit mem, bad, to;
    int n, acc, strobe_hi, wait_hi, ce_cyc, fault_cyc, rdw_cyc;
    bit in_strobe;
    mem       = rd | wr;
    bad       = (rd & wr) | (mem & (addr[1:0] != 2'b00));
    to        = mem && !bad && (waits >= T);
    acc       = waits + 1;
    ce_cyc    = -1;
    fault_cyc = -1;
    rdw_cyc   = -1;
    strobe_hi = 0;
    wait_hi   = 0;
    if (!mem) begin
      n = 1; ce_cyc = 0;
    end else if (bad) begin
      n = 2; fault_cyc = 1;
    end else if (to) begin
      n = T + 2; strobe_hi = T; wait_hi = T; fault_cyc = T + 1;
    end else if (wr) begin
      n = acc + 2; strobe_hi = acc; wait_hi = waits; ce_cyc = acc + 1;
    end else begin
      n = acc + 3; strobe_hi = acc; wait_hi = waits; rdw_cyc = acc + 1; ce_cyc = acc + 2;
    end
    ce_at      = -1;
    fault_seen = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (c == 0 || !scramble) begin
        cpu_data_read      = rd;
        cpu_data_write     = wr;
        cpu_data_address   = addr;
        cpu_data_writedata = wdata;
      end else begin
        cpu_data_read      = 1'($urandom);
        cpu_data_write     = 1'($urandom);
        cpu_data_address   = $urandom;
        cpu_data_writedata = $urandom;
      end
      in_strobe = (c >= 1) && (c <= strobe_hi);
      if (c >= 1 && c <= wait_hi)          avm_waitrequest = 1'b1;
      else if (in_strobe && c == acc)      avm_waitrequest = 1'b0;
      else                                 avm_waitrequest = 1'($urandom);
      avm_readdata = (c == rdw_cyc) ? rdata : $urandom;
      #1;
      chk("clk_enable", 32'(cpu_clk_enable), 32'(c == ce_cyc));
      chk("fault", 32'(fault), 32'(fault_cyc >= 0 && c >= fault_cyc));
      chk("avm_read", 32'(avm_read), 32'(in_strobe && !wr));
      chk("avm_write", 32'(avm_write), 32'(in_strobe && wr));
      if (in_strobe) begin
        chk("avm_address", avm_address, addr);
        if (wr) chk("avm_writedata", avm_writedata, wdata);
      end
      if (c == ce_cyc && rd) chk("cpu_readdata", cpu_data_readdata, rdata);
      if (cpu_clk_enable && ce_at < 0) ce_at = c;
      if (fault) fault_seen = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    int          exp_ce_at;
    bit          exp_fault;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int ce_at;
    bit fs;
    logic [31:0] r;
    int kind, w;
    logic rd, wr;

    vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0, 2, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 3, 32'h1234_5678, 6, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0203, 32'h0, 0, 32'h0, -1, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0040, 32'h5555_AAAA, 5, 32'h0, -1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0010, 32'h1, 0, 32'h0, -1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0, 0, 32'h0, 0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0, 0, 32'hA5A5_5A5A, 3, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_0202, 32'h7, 0, 32'h0, -1, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 3, 32'h0, 5, 1'b0};

    cpu_data_read = 1'b0; cpu_data_write = 1'b0;
    cpu_data_address = '0; cpu_data_writedata = '0;
    avm_readdata = '0; avm_waitrequest = 1'b0; reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_reset();
      chk("byteenable", 32'(avm_byteenable), 32'hF);
      do_instr(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
               vecs[i].rdata, 1'b0, ce_at, fs);
      chk_int($sformatf("vec%0d_ce_cycle", i), ce_at, vecs[i].exp_ce_at);
      chk_int($sformatf("vec%0d_fault", i), int'(fs), int'(vecs[i].exp_fault));
      if (vecs[i].exp_fault) begin
        for (int k = 0; k < 3; k++) begin
          #1; chk("stuck_ce", 32'(cpu_clk_enable), 32'd0);
          chk("sticky_fault", 32'(fault), 32'd1);
          @(posedge clk); #1;
        end
      end
    end

    // Reset during the second wait cycle of a store.
    do_reset();
    cpu_data_write = 1'b1; cpu_data_address = 32'h300; cpu_data_writedata = 32'h1111_2222;
    avm_waitrequest = 1'b1;
    #1; chk("mid_c0_ce", 32'(cpu_clk_enable), 32'd0);
    @(posedge clk); #1;
    chk("mid_c1_write", 32'(avm_write), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1; chk("mid_c2_ce", 32'(cpu_clk_enable), 32'd0);
    chk("mid_c2_write", 32'(avm_write), 32'd1);
    @(posedge clk); #1;
    chk("mid_post_write", 32'(avm_write), 32'd0);
    chk("mid_post_read", 32'(avm_read), 32'd0);
    chk("mid_post_fault", 32'(fault), 32'd0);
    chk("mid_post_rdata", cpu_data_readdata, 32'd0);
    reset = 1'b0; cpu_data_write = 1'b0;
    do_instr(1'b1, 1'b0, 32'h400, 32'h0, 1, 32'h0BAD_CAFE, 1'b0, ce_at, fs);
    chk_int("b2b_load_ce", ce_at, 4);
    do_instr(1'b0, 1'b1, 32'h404, 32'h0F0F_0F0F, 0, 32'h0, 1'b0, ce_at, fs);
    chk_int("b2b_store_ce", ce_at, 2);
    do_instr(1'b0, 1'b1, 32'h404, 32'h0F0F_0F0F, 0, 32'h0, 1'b0, ce_at, fs);
    chk_int("b2b_store2_ce", ce_at, 2);

    // Non-memory instruction stream.
    for (int k = 0; k < 6; k++) begin
      do_instr(1'b0, 1'b0, $urandom, $urandom, 0, 32'h0, 1'b0, ce_at, fs);
    end

    // Randomized instruction stream.
    for (int k = 0; k < 200; k++) begin
      kind = $urandom_range(0, 9);
      w    = ($urandom_range(0, 14) == 0) ? $urandom_range(T, T + 1) : $urandom_range(0, T - 1);
      r    = $urandom;
      rd   = 1'b0;
      wr   = 1'b0;
      if (kind >= 3 && kind <= 5) begin
        rd = 1'b1; r[1:0] = 2'b00;
      end else if (kind >= 6 && kind <= 8) begin
        wr = 1'b1; r[1:0] = 2'b00;
      end else if (kind == 9) begin
        rd = 1'($urandom); wr = 1'($urandom) | ~rd;
        if (!(rd && wr)) r[1:0] = 2'($urandom_range(1, 3));
      end
      do_instr(rd, wr, r, $urandom, w, $urandom, 1'($urandom), ce_at, fs);
      if (fs) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
